// File: rtl/rtc_pkg.sv
// rtc_pkg -- shared constants for the RTC bus scheduler.
//   * FSM state encoding (3 bits)
//   * RTC_TIME_ADDR: RTC register addresses read by a periodic sweep,
//     entry 0 is read first.
package rtc_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_GO   = 3'd1;
    localparam logic [2:0] ST_WR_WAIT = 3'd2;
    localparam logic [2:0] ST_RD_GO   = 3'd3;
    localparam logic [2:0] ST_RD_WAIT = 3'd4;
    localparam logic [2:0] ST_RD_NEXT = 3'd5;

    // Packed so that RTC_TIME_ADDR[i] is entry i (rightmost is entry 0).
    localparam logic [7:0][7:0] RTC_TIME_ADDR = {
        8'h28, 8'h27, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21
    };

endpackage

// File: rtl/rtc_refresh_tick.sv
// rtc_refresh_tick -- free-running refresh period counter.
// Counts 0..REFRESH_CYCLES-1 and wraps; tick is high during the cycle in
// which the counter holds its last value, i.e. tick marks the wrap edge.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; counter returns to 0
//   tick  : wrap indication, one cycle per period
module rtc_refresh_tick #(
    parameter int unsigned REFRESH_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned   CW   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)            cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

    assign tick = !reset && (cnt == LAST);

endmodule

// File: rtl/rtc_bus_sched.sv
// rtc_bus_sched -- arbitrates the shared RTC pins between user writes and
// a periodic read sweep of the time registers.
// A sweep reads NUM_REGS registers (addresses from RTC_TIME_ADDR) back to
// back and is never interrupted by a write; writes win only in IDLE.
// Optional build macro RTC_SCHED_TIMEOUT_EN: bounds every engine-done wait
// to TMO_CYCLES cycles and raises the sticky err flag on expiry. Without it
// waits are unbounded and err is constant 0.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   wr_req/wr_addr/wr_data    : user write request (held until wr_ack)
//   wr_ack                    : one-cycle pulse after the write completed
//   we / fesc                 : write-engine start / done
//   re / flec / lec_data      : read-engine start / done / returned byte
//   bus_sel                   : pin mux, 1 = write engine, 0 = read engine
//   addr_out, data_out        : address / write data for the active engine
//   reg_idx/reg_data/reg_valid: delivered time register
//   busy                      : FSM not in IDLE
//   err                       : sticky engine timeout flag
module rtc_bus_sched
    import rtc_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 1000000,
    parameter int unsigned NUM_REGS       = 6,
    parameter int unsigned TMO_CYCLES     = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       we,
    input  logic       fesc,
    output logic       re,
    input  logic       flec,
    input  logic [7:0] lec_data,
    output logic       bus_sel,
    output logic [7:0] addr_out,
    output logic [7:0] data_out,
    output logic [2:0] reg_idx,
    output logic [7:0] reg_data,
    output logic       reg_valid,
    output logic       busy,
    output logic       err
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);

    logic [2:0] state;
    logic [2:0] idx;
    logic [2:0] idx_nxt;
    logic       refresh_pend;
    logic       tick;
    logic       wait_expired;
    logic       tmo_hit;

    rtc_refresh_tick #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_refresh_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Engine strobes decode straight from the state register, so each is
    // exactly one cycle wide.
    assign we      = (state == ST_WR_GO);
    assign re      = (state == ST_RD_GO);
    assign busy    = (state != ST_IDLE);
    assign idx_nxt = idx + 3'd1;

    // Expiry only matters when the matching done has not arrived this cycle.
    assign tmo_hit = wait_expired &&
                     ((state == ST_WR_WAIT && !fesc) || (state == ST_RD_WAIT && !flec));

`ifdef RTC_SCHED_TIMEOUT_EN
    localparam int unsigned   TW       = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

    logic [TW-1:0] wait_cnt;

    // Cleared in the GO state so it reads 0 in the first WAIT cycle.
    always_ff @(posedge clk) begin
        if (reset)
            wait_cnt <= '0;
        else if (state == ST_WR_GO || state == ST_RD_GO)
            wait_cnt <= '0;
        else if (state == ST_WR_WAIT || state == ST_RD_WAIT)
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign wait_expired = (wait_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset)        err <= 1'b0;
        else if (tmo_hit) err <= 1'b1;
    end
`else
    assign wait_expired = 1'b0;
    assign err          = 1'b0;

    // TMO_CYCLES is only consumed by the timeout build.
    if (TMO_CYCLES == 0) begin : g_tmo_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            idx          <= 3'd0;
            refresh_pend <= 1'b0;
            wr_ack       <= 1'b0;
            reg_valid    <= 1'b0;
            bus_sel      <= 1'b0;
            addr_out     <= 8'h00;
            data_out     <= 8'h00;
            reg_idx      <= 3'd0;
            reg_data     <= 8'h00;
        end else begin
            wr_ack    <= 1'b0;
            reg_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // wr_req is still high during the ack cycle; ignore it
                    // there so one request is not serviced twice.
                    if (wr_req && !wr_ack) begin
                        addr_out <= wr_addr;
                        data_out <= wr_data;
                        bus_sel  <= 1'b1;
                        state    <= ST_WR_GO;
                    end else if (refresh_pend) begin
                        refresh_pend <= 1'b0;
                        idx          <= 3'd0;
                        bus_sel      <= 1'b0;
                        addr_out     <= RTC_TIME_ADDR[0];
                        state        <= ST_RD_GO;
                    end
                end
                ST_WR_GO: state <= ST_WR_WAIT;
                ST_WR_WAIT: begin
                    if (fesc) begin
                        wr_ack <= 1'b1;
                        state  <= ST_IDLE;
                    end else if (tmo_hit) begin
                        state  <= ST_IDLE;
                    end
                end
                ST_RD_GO: state <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    if (flec) begin
                        reg_data  <= lec_data;
                        reg_idx   <= idx;
                        reg_valid <= 1'b1;
                        state     <= ST_RD_NEXT;
                    end else if (tmo_hit) begin
                        state     <= ST_IDLE;
                    end
                end
                ST_RD_NEXT: begin
                    // Address is loaded here so it is stable for all of RD_GO.
                    if (idx < LAST_IDX) begin
                        idx      <= idx_nxt;
                        addr_out <= RTC_TIME_ADDR[idx_nxt];
                        state    <= ST_RD_GO;
                    end else begin
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // After the IDLE clear so a wrap on the sweep-start edge survives.
            if (tick) refresh_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rtc_bus_sched.sv
module tb_rtc_bus_sched;

    localparam int REF  = 100;
    localparam int NREG = 6;
    localparam int TMO  = 20;

    logic       clk;
    logic       reset;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       we;
    logic       fesc;
    logic       re;
    logic       flec;
    logic [7:0] lec_data;
    logic       bus_sel;
    logic [7:0] addr_out;
    logic [7:0] data_out;
    logic [2:0] reg_idx;
    logic [7:0] reg_data;
    logic       reg_valid;
    logic       busy;
    logic       err;

    rtc_bus_sched #(
        .REFRESH_CYCLES(REF),
        .NUM_REGS      (NREG),
        .TMO_CYCLES    (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .we       (we),
        .fesc     (fesc),
        .re       (re),
        .flec     (flec),
        .lec_data (lec_data),
        .bus_sel  (bus_sel),
        .addr_out (addr_out),
        .data_out (data_out),
        .reg_idx  (reg_idx),
        .reg_data (reg_data),
        .reg_valid(reg_valid),
        .busy     (busy),
        .err      (err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rc    = 0;    // cycles since reset modulo the refresh period
    int dly   = 10;   // engine done latency
    bit hold_done = 0;
    int rd_cd = 0;
    int wr_cd = 0;
    int fesc_cyc = 0;
    int ack_cnt = 0;

    logic [7:0]  re_addr_q[$];   // address seen at each re
    logic [7:0]  rd_data_q[$];   // byte returned at each flec
    logic [10:0] got_q[$];       // {reg_idx, reg_data} per reg_valid
    logic [15:0] wr_q[$];        // {addr, data} seen at each we
    logic [15:0] exp_wr[$];      // writes requested by the bench

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rc  <= reset ? 0 : ((rc == REF - 1) ? 0 : rc + 1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Engine model: done pulse dly cycles after the start strobe.
    initial begin
        fesc = 0; flec = 0; lec_data = 0;
        forever begin
            @(negedge clk);
            fesc = 0; flec = 0;
            if (rd_cd > 0) begin
                rd_cd--;
                if (rd_cd == 0 && !hold_done) begin
                    flec = 1; lec_data = 8'($urandom); rd_data_q.push_back(lec_data);
                end
            end else if (re === 1'b1) begin
                rd_cd = dly; re_addr_q.push_back(addr_out);
            end
            if (wr_cd > 0) begin
                wr_cd--;
                if (wr_cd == 0 && !hold_done) begin fesc = 1; fesc_cyc = cyc; end
            end else if (we === 1'b1) begin
                wr_cd = dly;
            end
        end
    end

    // Monitor: logs deliveries and checks bus-level invariants.
    initial begin
        logic prev_we = 0, prev_re = 0, prev_sel = 0, prev_busy = 0, prev_rst = 1;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (reg_valid) got_q.push_back({reg_idx, reg_data});
                if (wr_ack) ack_cnt++;
                if (we) begin
                    wr_q.push_back({addr_out, data_out});
                    check("we_bus_sel", bus_sel, 1);
                    check("we_one_cycle", prev_we, 0);
                    check("sweep_atomic", got_q.size() % NREG, 0);
                end
                if (re) begin
                    check("re_bus_sel", bus_sel, 0);
                    check("re_one_cycle", prev_re, 0);
                end
                if (!prev_rst && bus_sel !== prev_sel) check("sel_only_idle", prev_busy, 0);
            end
            prev_we = we; prev_re = re; prev_sel = bus_sel; prev_busy = busy; prev_rst = reset;
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_busy(input logic v, input int bound, input string tag);
        int n = 0;
        while (busy !== v && n < bound) begin step(); n++; end
        check(tag, busy, v);
    endtask

    task automatic wait_re(input int bound, input string tag);
        int n = 0;
        while (re !== 1'b1 && n < bound) begin step(); n++; end
        check(tag, re, 1);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int bound, input string tag);
        int n = 0;
        wr_addr = a; wr_data = d; wr_req = 1;
        exp_wr.push_back({a, d});
        while (wr_ack !== 1'b1 && n < bound) begin step(); n++; end
        check({tag, "_ack"}, wr_ack, 1);
        check({tag, "_ack_lat"}, cyc - fesc_cyc, 1);
        wr_req = 0; wr_addr = 8'($urandom); wr_data = 8'($urandom);
    endtask

    // Every delivery k must be register k mod NUM_REGS, read from the table
    // address and carrying the byte the engine returned.
    task automatic verify_reads(input string tag);
        check({tag, "_nrd"}, got_q.size(), rd_data_q.size());
        check({tag, "_nre"}, re_addr_q.size(), got_q.size());
        check({tag, "_whole"}, got_q.size() % NREG, 0);
        for (int k = 0; k < got_q.size() && k < rd_data_q.size() && k < re_addr_q.size(); k++) begin
            check({tag, "_idx"},  got_q[k][10:8], k % NREG);
            check({tag, "_data"}, got_q[k][7:0], rd_data_q[k]);
            check({tag, "_addr"}, re_addr_q[k], 8'h21 + k % NREG);
        end
        got_q.delete(); rd_data_q.delete(); re_addr_q.delete();
    endtask

    task automatic verify_writes(input string tag);
        check({tag, "_nwr"}, wr_q.size(), exp_wr.size());
        check({tag, "_nack"}, ack_cnt, exp_wr.size());
        for (int k = 0; k < wr_q.size() && k < exp_wr.size(); k++)
            check({tag, "_wr"}, wr_q[k], exp_wr[k]);
        wr_q.delete(); exp_wr.delete(); ack_cnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, we, 0);
        check({tag, "_re"}, re, 0);
        check({tag, "_wr_ack"}, wr_ack, 0);
        check({tag, "_reg_valid"}, reg_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_bus_sel"}, bus_sel, 0);
        check({tag, "_addr_out"}, addr_out, 0);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_reg_idx"}, reg_idx, 0);
        check({tag, "_reg_data"}, reg_data, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        int n;
        reset = 1; wr_req = 0; wr_addr = 0; wr_data = 0;

        // Reset state
        step(); step();
        check_reset_outputs("rst");
        reset = 0;

        // First periodic sweep, done returned 10 cycles after each start
        wait_busy(1, 150, "sweep1_start");
        wait_busy(0, 200, "sweep1_end");
        verify_reads("sweep1");

        // Plain write in IDLE
        do_write(8'h22, 8'h59, 40, "wr1");
        check("wr1_bus_sel", bus_sel, 1);
        check("wr1_addr_out", addr_out, 8'h22);
        check("wr1_data_out", data_out, 8'h59);
        step();
        check("wr1_ack_pulse", wr_ack, 0);
        verify_writes("wr1");

        // Write request on the same edge as the refresh wrap
        n = 0;
        while (rc != REF - 1 && n < 200) begin step(); n++; end
        check("coinc_align", rc, REF - 1);
        do_write(8'($urandom), 8'($urandom), 40, "coinc");
        check("coinc_no_read_first", re_addr_q.size(), 0);
        step();
        check("coinc_sweep_next", re, 1);
        wait_busy(0, 200, "coinc_sweep_end");
        verify_reads("coinc");
        verify_writes("coinc");

        // Write raised mid-sweep at reg_idx 2 must wait for the whole sweep
        n = 0;
        while (!(reg_valid === 1'b1 && reg_idx == 3'd2) && n < 300) begin step(); n++; end
        check("mid_idx2", {reg_valid, reg_idx}, 4'b1010);
        do_write(8'($urandom), 8'($urandom), 200, "mid");
        check("mid_sweep_done_first", got_q.size(), NREG);
        wait_busy(0, 200, "mid_end");
        verify_reads("mid");
        verify_writes("mid");

        // Random writes at random times with random engine latency
        for (int i = 0; i < 5; i++) begin
            dly = $urandom_range(2, 12);
            repeat ($urandom_range(0, 80)) step();
            do_write(8'($urandom), 8'($urandom), 400, "rnd");
        end
        repeat (3) step();
        wait_busy(0, 300, "rnd_end");
        verify_reads("rnd");
        verify_writes("rnd");
        dly = 10;

`ifdef RTC_SCHED_TIMEOUT_EN
        // Withheld read done: err after TMO wait cycles, back to IDLE
        begin
            int c0;
            hold_done = 1;
            wait_re(250, "tmo_re");
            c0 = cyc;
            n = 0;
            while (err !== 1'b1 && n < 40) begin step(); n++; end
            check("tmo_err", err, 1);
            check("tmo_cycle", cyc - c0, TMO + 1);
            check("tmo_idle", busy, 0);
            check("tmo_no_valid", got_q.size(), 0);
            step();
            hold_done = 0;
            got_q.delete(); rd_data_q.delete(); re_addr_q.delete();
        end
`endif

        // Reset while waiting for read done
        wait_re(250, "rstmid_re");
        step(); step(); step();
        check("rstmid_in_wait", busy, 1);
        reset = 1;
        step();
        check_reset_outputs("rstmid");
        reset = 0;
        repeat (15) step();
        check("rstmid_no_valid", got_q.size(), 0);
        check("rstmid_idle", busy, 0);
        check("final_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rtc_bus_sched.md
RTC_BUS_SCHED -- requirements
Module: rtc_bus_sched

Interface
REQ-001 The block SHALL have parameter REFRESH_CYCLES, default 1000000, clk cycles between periodic read sweeps (minimum 16).
REQ-002 The block SHALL have parameter NUM_REGS, default 6, number of time registers read per sweep (range 1..8).
REQ-003 The block SHALL have parameter TMO_CYCLES, default 255, maximum engine-done wait in clk cycles.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock, all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port wr_req, input, 1 bit: user write request, held until wr_ack.
REQ-007 The block SHALL have port wr_addr, input, 8 bits: RTC register address for the user write.
REQ-008 The block SHALL have port wr_data, input, 8 bits: data for the user write.
REQ-009 The block SHALL have port wr_ack, output, 1 bit: one-cycle pulse when the user write has completed on the bus.
REQ-010 The block SHALL have port we, output, 1 bit: write-engine start.
REQ-011 The block SHALL have port fesc, input, 1 bit: write-engine done pulse.
REQ-012 The block SHALL have port re, output, 1 bit: read-engine start.
REQ-013 The block SHALL have port flec, input, 1 bit: read-engine done pulse.
REQ-014 The block SHALL have port lec_data, input, 8 bits: byte returned by the read engine, valid with flec.
REQ-015 The block SHALL have port bus_sel, output, 1 bit: RTC pin mux select, 1 = write engine, 0 = read engine.
REQ-016 The block SHALL have port addr_out, output, 8 bits: address presented to the active engine.
REQ-017 The block SHALL have port data_out, output, 8 bits: write data presented to the write engine.
REQ-018 The block SHALL have port reg_idx, output, 3 bits: index of the time register delivered.
REQ-019 The block SHALL have port reg_data, output, 8 bits: byte delivered.
REQ-020 The block SHALL have port reg_valid, output, 1 bit: one-cycle strobe qualifying reg_idx/reg_data.
REQ-021 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-022 The block SHALL have port err, output, 1 bit: sticky timeout flag.

Function
REQ-023 The FSM SHALL use states IDLE, WR_GO, WR_WAIT, RD_GO, RD_WAIT, RD_NEXT, encoded in 3 bits.
REQ-024 A free-running refresh counter SHALL count 0..REFRESH_CYCLES-1, wrap to 0, and set refresh_pend on wrap.
REQ-025 In IDLE with wr_req=1, the FSM SHALL capture wr_addr/wr_data into addr_out/data_out, set bus_sel=1, and go to WR_GO; a write wins over refresh_pend on the same cycle.
REQ-026 In IDLE with refresh_pend=1 and wr_req=0, the FSM SHALL clear refresh_pend, load idx=0, set bus_sel=0, and go to RD_GO.
REQ-027 WR_GO SHALL assert we for exactly one cycle and then move to WR_WAIT.
REQ-028 WR_WAIT on fesc=1 SHALL pulse wr_ack and return to IDLE.
REQ-029 RD_GO SHALL drive addr_out=RTC_TIME_ADDR[idx], assert re for exactly one cycle, and then move to RD_WAIT.
REQ-030 RD_WAIT on flec=1 SHALL register lec_data to reg_data and idx to reg_idx, pulse reg_valid for one cycle, and move to RD_NEXT.
REQ-031 RD_NEXT SHALL increment idx and go to RD_GO if idx<NUM_REGS-1, else go to IDLE.
REQ-032 A read sweep SHALL be atomic: wr_req arriving mid-sweep SHALL wait, unacknowledged, until the FSM returns to IDLE.
REQ-033 A refresh wrap during a sweep or write SHALL set refresh_pend and SHALL NOT be lost; multiple wraps SHALL collapse into one pending sweep.
REQ-034 bus_sel SHALL change only in IDLE, never while an engine is running.
REQ-035 fesc/flec arriving in any state other than the matching WAIT SHALL be ignored.

Reset
REQ-036 On reset=1 at a rising clk edge, the block SHALL set state=IDLE, refresh counter=0, refresh_pend=0, idx=0, err=0.
REQ-037 On reset, outputs SHALL be: we=0, re=0, wr_ack=0, reg_valid=0, busy=0, bus_sel=0, addr_out=0, data_out=0, reg_idx=0, reg_data=0.
REQ-038 Reset mid-operation SHALL abandon the transfer immediately with no wr_ack or reg_valid.

Configuration
REQ-039 With RTC_SCHED_TIMEOUT_EN defined, a wait counter SHALL clear on entry to WR_WAIT/RD_WAIT; reaching TMO_CYCLES without done SHALL set err, return to IDLE, and produce no wr_ack/reg_valid (the pending write remains requested).
REQ-040 Without RTC_SCHED_TIMEOUT_EN, WAIT states SHALL wait indefinitely and err SHALL be tied to 0.

Structure
REQ-041 Package rtc_pkg SHALL hold the state encoding constants and the RTC_TIME_ADDR table (8'h21,8'h22,8'h23,8'h24,8'h25,8'h26,8'h27,8'h28).
REQ-042 The refresh counter SHALL be a sub-module rtc_refresh_tick (tick output on wrap).

Verification
REQ-043 Bench: REFRESH_CYCLES=100, NUM_REGS=6, done returned 10 cycles after start -> six reg_valid pulses with reg_idx 0..5 and addresses 21..26 in order, then busy=0.
REQ-044 Bench: wr_req with addr 8'h22, data 8'h59 in IDLE -> bus_sel=1, one-cycle we with addr_out=8'h22 and data_out=8'h59, then wr_ack one cycle after fesc.
REQ-045 Bench: wr_req and refresh tick in the same cycle -> write serviced first, sweep starts on the first IDLE after wr_ack.
REQ-046 Bench: wr_req raised during reg_idx=2 of a sweep -> no we until idx 5 delivered; wr_ack follows afterwards.
REQ-047 Bench: with RTC_SCHED_TIMEOUT_EN and TMO_CYCLES=20, flec withheld -> err=1 at wait cycle 20, FSM in IDLE, no reg_valid.
REQ-048 Bench: reset asserted in RD_WAIT -> next cycle all outputs at reset values, and no reg_valid even if flec arrives.
